// File: rtl/memory_responder_pkg.sv
// Shared types for the MemoryBus memory responder: access-size encoding,
// responder FSM states and the byte-lane enable helper.
package memory_responder_pkg;

  // Access size carried on the MemoryBus ws lines
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BYTE  = 2'd1,
    HALF  = 2'd2,
    WORD  = 2'd3
  } ws_t;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } responder_state_t;

  localparam int NUM_LANES = 4;

  // Byte-lane enables for a write of size ws at byte offset lane
  function automatic logic [NUM_LANES-1:0] lane_enable(input ws_t ws, input logic [1:0] lane);
    logic [NUM_LANES-1:0] be;
    be = '0;
    case (ws)
      WORD:    be = 4'b1111;
      HALF:    be = lane[1] ? 4'b1100 : 4'b0011;
      BYTE:    be = 4'b0001 << lane;
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_lane_array.sv
// Word-organised RAM with a per-byte-lane synchronous write port and an
// asynchronous read port sharing one word index.
module mem_lane_array
  import memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic                  i_clk,
  input  logic [NUM_LANES-1:0]  i_be,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int LANE_W = DATA_WIDTH / NUM_LANES;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // Write only the enabled lanes; unselected lanes keep their contents
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (i_be[l]) begin
        r_mem[i_idx][l*LANE_W +: LANE_W] <= i_wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/memory_responder.sv
// MemoryBus memory-side responder: accepts one read or write at a time,
// waits the configured latency, then performs the access and holds
// ready/done until the initiator drops its request.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_WORDS     = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic                  source,
  input  logic [1:0]            ws,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  done,
  output logic                  resp_source
);

  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int LANE_W  = DATA_WIDTH / NUM_LANES;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  // Place right-aligned write data onto every lane it might target
  function automatic logic [DATA_WIDTH-1:0] lane_data(input ws_t sz, input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] o;
    o = d;
    case (sz)
      BYTE:    o = {NUM_LANES{d[LANE_W-1:0]}};
      HALF:    o = {2{d[2*LANE_W-1:0]}};
      default: o = d;
    endcase
    return o;
  endfunction

  responder_state_t      r_state;
  responder_state_t      w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_op_read;
  logic                  r_src;
  logic                  r_ready;
  logic                  r_done;
  logic                  w_ready_nxt;
  logic                  w_done_nxt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [IDX_W+1:0]      r_addr;
  ws_t                   r_ws;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_accept;
  logic                  w_capture;
  logic                  w_commit;
  logic                  w_req_held;
  logic [NUM_LANES-1:0]  w_be;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic                  w_unused_addr;

  // Address bits above the array index alias (wrap modulo MEM_WORDS)
  assign w_unused_addr = ^address[ADDR_WIDTH-1:IDX_W+2];

  // Next-state, counter and response decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_done_nxt  = r_done;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    w_req_held  = r_op_read ? read : write;
    case (r_state)
      IDLE: begin
        if (read || write) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
          w_cnt_nxt   = read ? RD_LOAD : WR_LOAD;
        end
      end
      BUSY: begin
        if (!w_req_held) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = RESPOND;
          if (r_op_read) begin
            w_ready_nxt = 1'b1;
            w_capture   = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
            w_commit   = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESPOND: begin
        if (!w_req_held) begin
          w_ready_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, counter, response flags and read data register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op_read <= 1'b0;
      r_src     <= 1'b0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_op_read <= read;
        r_src     <= source;
      end
      if (w_capture) begin
        r_rdata <= w_mem_rdata;
      end
    end
  end

  // Request attributes latched at accept; later input changes are ignored
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= address[IDX_W+1:0];
      r_ws    <= ws_t'(ws);
      r_wdata <= wdata;
    end
  end

  // A write held in reset on its commit edge must not reach the array
  assign w_be        = (w_commit && reset) ? lane_enable(r_ws, r_addr[1:0]) : '0;
  assign w_mem_wdata = lane_data(r_ws, r_wdata);

  mem_lane_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .i_clk   (clk),
    .i_be    (w_be),
    .i_idx   (r_addr[IDX_W+1:2]),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign rdata       = r_rdata;
  assign ready       = r_ready;
  assign done        = r_done;
  assign resp_source = r_src;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: vector table driven through a
// response scoreboard, plus hand sequences for priority, abort and reset.
module tb_memory_responder;
  import memory_responder_pkg::*;

  localparam int RL      = 2;
  localparam int WL      = 2;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        source;
  logic [1:0]  ws;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        done;
  logic        resp_source;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [1:0]  wsz;
    logic [31:0] wd;
    bit          src;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          src;
    bit          is_rd;
    bit          chk;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[22];

  memory_responder #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .MEM_WORDS     (1024),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .read        (read),
    .write       (write),
    .source      (source),
    .ws          (ws),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .done        (done),
    .resp_source (resp_source)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Count edges until the selected response rises, bounded by TIMEOUT
  task automatic wait_resp(input bit is_rd, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (((is_rd ? ready : done) !== 1'b1) && (k < TIMEOUT));
  endtask

  task automatic run_txn(input string tag, input bit is_rd, input logic [31:0] addr,
                         input logic [1:0] wsz, input logic [31:0] wd, input bit src,
                         input bit chk_data, input logic [31:0] exp);
    sb_t e;
    int  k;
    address = addr; ws = wsz; wdata = wd; source = src;
    read = is_rd; write = !is_rd;
    e.data = exp; e.src = src; e.is_rd = is_rd; e.chk = chk_data;
    sb.push_back(e);
    tick();
    address = ~addr; wdata = ~wd; ws = ~wsz; source = !src;
    wait_resp(is_rd, k);
    check({tag, "_latency"}, k, is_rd ? RL : WL);
    check({tag, "_other_resp"}, is_rd ? done : ready, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_resp_source"}, resp_source, e.src);
      if (e.is_rd && e.chk) check({tag, "_rdata"}, rdata, e.data);
    end
    tick();
    check({tag, "_hold"}, is_rd ? ready : done, 1);
    if (e.is_rd && e.chk) check({tag, "_hold_rdata"}, rdata, e.data);
    read = 0; write = 0;
    tick();
    check({tag, "_release"}, {ready, done}, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen;

    vecs[0]  = '{0, 32'h10,   WORD,  32'hDEADBEEF, 0, 32'h0};
    vecs[1]  = '{1, 32'h10,   WORD,  32'h0,        1, 32'hDEADBEEF};
    vecs[2]  = '{0, 32'h20,   WORD,  32'h11223344, 1, 32'h0};
    vecs[3]  = '{1, 32'h20,   WORD,  32'h0,        0, 32'h11223344};
    vecs[4]  = '{0, 32'h22,   BYTE,  32'h000000AA, 0, 32'h0};
    vecs[5]  = '{1, 32'h20,   BYTE,  32'h0,        1, 32'h11AA3344};
    vecs[6]  = '{0, 32'h20,   HALF,  32'h0000BEEF, 1, 32'h0};
    vecs[7]  = '{1, 32'h20,   HALF,  32'h0,        0, 32'h11AABEEF};
    vecs[8]  = '{0, 32'h23,   HALF,  32'h12345678, 0, 32'h0};
    vecs[9]  = '{1, 32'h23,   EMPTY, 32'h0,        1, 32'h5678BEEF};
    vecs[10] = '{0, 32'h21,   BYTE,  32'h000000C3, 1, 32'h0};
    vecs[11] = '{1, 32'h20,   WORD,  32'h0,        0, 32'h5678C3EF};
    vecs[12] = '{0, 32'h1000, WORD,  32'hCAFEF00D, 0, 32'h0};
    vecs[13] = '{1, 32'h0,    WORD,  32'h0,        1, 32'hCAFEF00D};
    vecs[14] = '{0, 32'h0,    EMPTY, 32'hFFFFFFFF, 1, 32'h0};
    vecs[15] = '{1, 32'h1000, WORD,  32'h0,        0, 32'hCAFEF00D};
    vecs[16] = '{0, 32'hFFF,  WORD,  32'hA5A55A5A, 0, 32'h0};
    vecs[17] = '{1, 32'h1FFC, WORD,  32'h0,        1, 32'hA5A55A5A};
    vecs[18] = '{0, 32'h4,    WORD,  32'h44444444, 1, 32'h0};
    vecs[19] = '{1, 32'h4,    WORD,  32'h0,        0, 32'h44444444};
    vecs[20] = '{0, 32'h13,   BYTE,  32'h000000FF, 0, 32'h0};
    vecs[21] = '{1, 32'h10,   WORD,  32'h0,        1, 32'hFFADBEEF};

    reset = 0; read = 1; write = 0; source = 1; ws = WORD;
    address = 32'h10; wdata = 32'h0;

    // Reset held with a read pending: no response, outputs cleared
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_flags", {ready, done, resp_source}, 0);
      check("reset_rdata", rdata, 0);
    end
    reset = 1;
    run_txn("post_reset_read", 1, 32'h10, WORD, 32'h0, 1, 0, 32'h0);

    for (int i = 0; i < 22; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].wsz,
              vecs[i].wd, vecs[i].src, 1, vecs[i].exp);
    end

    // Simultaneous read and write: read wins, write follows once read drops
    address = 32'h10; ws = WORD; wdata = 32'h99999999; source = 1;
    read = 1; write = 1;
    tick();
    wait_resp(1, k);
    check("rw_read_latency", k, RL);
    check("rw_no_done", done, 0);
    check("rw_rdata", rdata, 32'hFFADBEEF);
    read = 0;
    tick();
    check("rw_gap", {ready, done}, 0);
    wait_resp(0, k);
    check("rw_write_latency", k, WL + 1);
    check("rw_write_ready_low", ready, 0);
    write = 0;
    tick();
    check("rw_write_release", done, 0);
    tick();
    run_txn("rw_readback", 1, 32'h10, WORD, 32'h0, 0, 1, 32'h99999999);

    // Write dropped during BUSY: no done, no commit
    address = 32'h4; ws = WORD; wdata = 32'h77777777; source = 0; write = 1;
    tick();
    write = 0;
    seen = 0;
    repeat (6) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    check("abort_no_done", seen, 0);
    run_txn("abort_readback", 1, 32'h4, WORD, 32'h0, 1, 1, 32'h44444444);

    // Reset on the commit edge of a write: aborted, array unchanged
    address = 32'h4; ws = WORD; wdata = 32'h55555555; source = 1; write = 1;
    tick();
    tick();
    reset = 0;
    tick();
    check("reset_busy_flags", {ready, done, resp_source}, 0);
    write = 0;
    reset = 1;
    tick();
    check("reset_busy_idle", {ready, done}, 0);
    run_txn("reset_busy_readback", 1, 32'h4, WORD, 32'h0, 0, 1, 32'h44444444);

    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the MemoryBus protocol: the other end of the CPU MMU, which arbitrates instruction and data requests onto MemoryBus.
- Accepts one read or write request at a time and models a word-addressed RAM with configurable access latency.
- Answers reads with `ready` plus the data word, and writes with `done`. Both are held until the initiator drops its request.
- Sits at top level between the MMU and the backing store. A top-level wrapper maps `rdata`/`wdata` onto the tri-state MemoryBus data lines.

Parameters:
ADDR_WIDTH, 32, width of address bus
DATA_WIDTH, 32, data word width (fixed 4 byte lanes)
MEM_WORDS, 1024, number of words in array (power of 2)
READ_LATENCY, 2, cycles from request accept to ready (>=1)
WRITE_LATENCY, 2, cycles from request accept to done (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
address  in  ADDR_WIDTH  byte address from initiator
read  in  1  read request, held until ready seen
write  in  1  write request, held until done seen
source  in  1  requester tag (0 instr, 1 data)
ws  in  2  access size: EMPTY/BYTE/HALF/WORD (CustomTypes)
wdata  in  DATA_WIDTH  write data, right-aligned (byte in [7:0], half in [15:0])
rdata  out  DATA_WIDTH  read data word, valid while ready=1
ready  out  1  read response
done  out  1  write response
resp_source  out  1  source tag captured at accept, valid with ready/done

Behaviour:
- Reset (`reset`=0 at a rising edge):
  - State goes to IDLE; `ready`, `done`, `resp_source` and counter become 0; `rdata` becomes 0.
  - Memory array is NOT cleared.
  - Reset mid-operation aborts the access; a pending write is not committed.
- FSM states: IDLE, BUSY, RESPOND.
- IDLE:
  - If `read`=1 the read is accepted. Read has priority when `read` and `write` are both 1.
  - Otherwise if `write`=1 the write is accepted.
  - On accept: latch address, op, source, ws, wdata; load counter with LAT-1; go to BUSY.
- BUSY:
  - Each cycle, if the request for the latched op has dropped, abort to IDLE with no commit and no response.
  - Else if counter=0, perform the access and go to RESPOND with `ready` (read) or `done` (write) =1. Otherwise decrement the counter.
  - Changes to the input address, ws or wdata during BUSY are ignored; the latched values are used.
- Latency: if a request is sampled at edge N, the response is high after edge N+LAT. With LAT=1, the response is visible in the cycle after accept.
- RESPOND:
  - Hold `ready`/`done`, `rdata` and `resp_source` stable while the latched request stays high.
  - On the first edge with that request low, clear `ready`/`done` and go to IDLE.
  - A new request can be accepted at the earliest one cycle later. This guarantees the MMU observes a cycle with `ready`=`done`=0 between transactions.
- Indexing: word index = `address[log2(MEM_WORDS)+1:2]`. Addresses beyond MEM_WORDS wrap modulo MEM_WORDS.
- Reads always return the full aligned word; ws is ignored. The initiator slices.
- Writes by ws:
  - WORD: ignores `address[1:0]` and writes all 4 lanes.
  - HALF: lane pair `address[1]` (0: [15:0], 1: [31:16]); `address[0]` is ignored.
  - BYTE: lane `address[1:0]`; `wdata[7:0]` is replicated to the selected lane.
  - EMPTY: no array change, but `done` is still returned.
- Unselected lanes are always preserved.
- Read-after-write: a read accepted after a write's `done` observes the written data.

Decomposition:
- CustomTypes package: existing ws enum (EMPTY=0, BYTE=1, HALF=2, WORD=3); add the `responder_state_t` enum {IDLE, BUSY, RESPOND}.
- Sub-module `mem_lane_array`:
  - Synchronous word array with a 4-bit byte-enable write port and combinational read port.
  - Byte-enable and lane-shift generation live in `memory_responder`.

Test Plan:
- Reset, LAT=2: reset=0 for 2 cycles while read=1 -> ready=0, done=0; after release the read is accepted and ready=1 exactly 2 cycles after the accept edge.
- WORD write 0xDEADBEEF @0x10, then read @0x10 with source=1 -> done asserts after 2 cycles; read returns rdata=0xDEADBEEF, resp_source=1; ready drops one cycle after read deasserts.
- Mem @0x20=0x11223344; BYTE write wdata=0xAA @0x22, then HALF write 0xBEEF @0x20 -> read gives 0x11AA3344, then 0x11AABEEF.
- read=1 and write=1 in same IDLE cycle -> read serviced (ready=1, done=0), memory unchanged; write serviced after read completes and both requests are re-presented.
- Write @0x4 with write dropped during BUSY -> no done, word @0x4 unchanged; reset=0 mid-BUSY of another write -> state IDLE, no commit.
- Address 0x1000 with MEM_WORDS=1024 -> aliases word 0; ws=EMPTY write -> done=1, array unchanged.
